// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Shared types and constants for the uart_rx_ext receiver.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int baud_cnt_width(input int bit_div);
    return (bit_div > 1) ? $clog2(bit_div) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_sampler
// RX pin synchroniser, falling-edge detect, bit-period counter and
// mid-bit 3-sample majority vote.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int BIT_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_pin,
  input  logic restart,
  output logic fall_edge,
  output logic bit_val,
  output logic bit_strobe,
  output logic wrap
);

  localparam int MID = BIT_DIV / 2;
  localparam int CW  = baud_cnt_width(BIT_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(MID);
  localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          armed;
  logic [1:0]    fill;
  logic [CW-1:0] baud_cnt;
  logic          samp0;
  logic          samp1;

  // armed only once a genuine high has propagated through the synchroniser,
  // so the reset value of the flops cannot fake an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
      prev  <= sync2;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && sync2) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      baud_cnt <= '0;
    end else if (wrap) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp0 <= 1'b1;
      samp1 <= 1'b1;
    end else begin
      if (baud_cnt == CNT_S0) samp0 <= sync2;
      if (baud_cnt == CNT_S1) samp1 <= sync2;
    end
  end

  assign fall_edge  = armed & prev & ~sync2;
  assign wrap       = (baud_cnt == CNT_LAST);
  assign bit_strobe = (baud_cnt == CNT_S2);
  assign bit_val    = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ext
// Parametrised UART receiver, LSB first, hold-until-ack output with frame,
// parity and overrun reporting. Parity is built only with UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int BIT_DIV     = 434,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 RST_clk,
  input  logic                 RST_n,
  input  logic                 uart_rx_data,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 uart_over,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP   = STOP;

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PARITY_NONE);
`else
  // PARITY_MODE has no effect without the parity build.
  localparam bit PAR_ON = 1'b0 & (PARITY_MODE != PARITY_NONE);
`endif

  logic [2:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_acc;
  logic                 fall_edge;
  logic                 bit_val;
  logic                 bit_strobe;
  logic                 wrap;
  logic                 restart;
  logic                 commit;

  assign restart = (state == S_IDLE) && fall_edge;
  assign commit  = (state == S_STOP) && bit_strobe && (bit_cnt == LAST_STOP);
  assign busy    = (state != S_IDLE);

  uart_rx_sampler #(
    .BIT_DIV (BIT_DIV)
  ) u_sampler (
    .clk        (RST_clk),
    .rst        (RST_n),
    .rx_pin     (uart_rx_data),
    .restart    (restart),
    .fall_edge  (fall_edge),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .wrap       (wrap)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge RST_clk) begin
    if (RST_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fall_edge) state <= S_START;
        end
        S_START: begin
          if (bit_strobe && bit_val) begin
            state <= S_IDLE;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_strobe) shreg[bit_cnt] <= bit_val;
          if (wrap) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt  <= '0;
              ferr_acc <= 1'b0;
              state    <= PAR_ON ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_strobe) par_bit <= bit_val;
          if (wrap) state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Leave at the last stop decision so a back-to-back start is seen.
          if (bit_strobe) begin
            if (!bit_val) ferr_acc <= 1'b1;
            if (bit_cnt == LAST_STOP) state <= S_IDLE;
          end else if (wrap) begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge RST_clk) begin
    if (RST_n) begin
      rx_data   <= '0;
      uart_over <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      rx_data   <= shreg;
      frame_err <= ferr_acc | ~bit_val;
      uart_over <= 1'b1;
      if (uart_over && !rx_ack) overrun <= 1'b1;
    end else if (rx_ack && uart_over) begin
      uart_over <= 1'b0;
      overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_err = PAR_ON && ((^shreg ^ par_bit) != (PARITY_MODE == PARITY_ODD));

  always_ff @(posedge RST_clk) begin
    if (RST_n) begin
      parity_err <= 1'b0;
    end else if (commit) begin
      parity_err <= par_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ext
// Self-checking bench for uart_rx_ext with a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

  localparam int BD  = 16;
  localparam int MID = BD / 2;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_RX_PARITY_EN
  localparam int PMODE = 2;
  localparam int PB    = 1;
`else
  localparam int PMODE = 0;
  localparam int PB    = 0;
`endif
  localparam int F   = 1 + DB + PB + SB - 1;
  // Pin drop -> edge detect is 3 cycles, then F*BD + MID + 2 to uart_over.
  localparam int LAT = 3 + F * BD + MID + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line = 1'b1;
  logic          ack_dir = 1'b0;
  logic          ack_rnd = 1'b0;
  logic          ack;
  logic [DB-1:0] rx_data;
  logic          uart_over, frame_err, parity_err, overrun, busy;

  assign ack = ack_dir | ack_rnd;

  uart_rx_ext #(
    .BIT_DIV     (BD),
    .DATA_BITS   (DB),
    .PARITY_MODE (PMODE),
    .STOP_BITS   (SB)
  ) dut (
    .RST_clk      (clk),
    .RST_n        (rst),
    .uart_rx_data (line),
    .rx_ack       (ack),
    .rx_data      (rx_data),
    .uart_over    (uart_over),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit started  = 1'b0;
  bit rnd_en   = 1'b0;

  typedef struct {
    int            at;
    logic [DB-1:0] data;
    bit            ferr;
    bit            perr;
  } commit_t;

  commit_t cq[$];
  int      busy_on_q[$];
  int      busy_off_q[$];
  commit_t cur;

  logic [DB-1:0] e_data = '0;
  bit e_over = 0, e_ferr = 0, e_perr = 0, e_ovr = 0, e_busy = 0;
  int rise_cyc  = -1;
  bit prev_over = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit commit_at(input int t);
    foreach (cq[i]) if (cq[i].at == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit good_par(input logic [DB-1:0] d);
    return ~(^d);
  endfunction

  // Reference model: word-level hold/ack/overrun rules at each clock edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      e_data = '0; e_over = 0; e_ferr = 0; e_perr = 0; e_ovr = 0; e_busy = 0;
      cq.delete(); busy_on_q.delete(); busy_off_q.delete();
    end else begin
      if (busy_on_q.size() > 0 && busy_on_q[0] == cyc) begin
        e_busy = 1'b1;
        void'(busy_on_q.pop_front());
      end
      if (busy_off_q.size() > 0 && busy_off_q[0] == cyc) begin
        e_busy = 1'b0;
        void'(busy_off_q.pop_front());
      end
      if (cq.size() > 0 && cq[0].at == cyc) begin
        cur = cq.pop_front();
        if (e_over && !ack) e_ovr = 1'b1;
        e_over = 1'b1;
        e_data = cur.data;
        e_ferr = cur.ferr;
        e_perr = cur.perr;
      end else if (ack && e_over) begin
        e_over = 1'b0;
        e_ovr  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmp_rx_data",    rx_data,    e_data);
      check("cmp_uart_over",  uart_over,  e_over);
      check("cmp_frame_err",  frame_err,  e_ferr);
      check("cmp_parity_err", parity_err, e_perr);
      check("cmp_overrun",    overrun,    e_ovr);
      check("cmp_busy",       busy,       e_busy);
      if (uart_over === 1'b1 && !prev_over) rise_cyc = cyc;
      prev_over = (uart_over === 1'b1);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ack_rnd = rnd_en && ($urandom_range(0, 9) == 0) && !commit_at(cyc + 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack_dir = 1'b1;
    tick(1);
    ack_dir = 1'b0;
  endtask

  // Drives one frame; abort_bit >= 0 pulses reset during that data bit.
  task automatic send_frame(input logic [DB-1:0] d, input bit stop_bad, input bit pbit,
                            input int abort_bit, output int e0);
    bit perr;
    e0   = cyc;
    line = 1'b0;
    perr = (PB == 1) ? ((^d ^ pbit) != 1'b1) : 1'b0;
    busy_on_q.push_back(e0 + 3);
    if (abort_bit < 0) begin
      cq.push_back('{at: e0 + LAT, data: d, ferr: stop_bad, perr: perr});
      busy_off_q.push_back(e0 + LAT);
    end else begin
      busy_off_q.push_back(e0 + 1000000);
    end
    tick(BD);
    for (int i = 0; i < DB; i++) begin
      line = d[i];
      if (i == abort_bit) begin
        tick(MID);
        rst = 1'b1;
        tick(1);
        rst  = 1'b0;
        line = 1'b1;
        check("rst_rx_data", rx_data, 0);
        check("rst_uart_over", uart_over, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        tick(BD - MID - 1 + (DB - 1 - i) * BD + (PB + SB) * BD);
        return;
      end
      tick(BD);
    end
    if (PB == 1) begin
      line = pbit;
      tick(BD);
    end
    for (int s = 0; s < SB; s++) begin
      line = stop_bad ? 1'b0 : 1'b1;
      tick(BD);
    end
    line = 1'b1;
  endtask

  task automatic glitch_pulse(input int len);
    int e0;
    e0   = cyc;
    line = 1'b0;
    busy_on_q.push_back(e0 + 3);
    busy_off_q.push_back(e0 + 3 + MID + 2);
    tick(len);
    line = 1'b1;
    tick(2 * BD - len);
  endtask

  initial begin
    int            e;
    int            gap;
    bit            bad;
    bit            pbit;
    logic [DB-1:0] d;

    rst  = 1'b1;
    line = 1'b1;
    tick(4);
    rst     = 1'b0;
    started = 1'b1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_uart_over", uart_over, 0);
    check("reset_busy", busy, 0);
    tick(6);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, good_par(8'hA5), -1, e);
    check("a5_latency", rise_cyc - e, (PB == 1) ? 173 : 157);
    check("a5_data", rx_data, 8'hA5);
    check("a5_frame_err", frame_err, 0);
    pulse_ack();
    tick(1);
    check("a5_ack_clears", uart_over, 0);

    // short low glitch
    glitch_pulse(4);
    check("glitch_no_over", uart_over, 0);
    check("glitch_idle", busy, 0);

    // bad stop bit
    send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, e);
    tick(2);
    check("3c_data", rx_data, 8'h3C);
    check("3c_frame_err", frame_err, 1);
    pulse_ack();
    tick(2);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1, -1, e);
    tick(2);
    check("par_bad", parity_err, 1);
    pulse_ack();
    send_frame(8'h01, 1'b0, 1'b0, -1, e);
    tick(2);
    check("par_good", parity_err, 0);
    pulse_ack();
    tick(2);
`endif

    // back-to-back frames without ack
    send_frame(8'h11, 1'b0, good_par(8'h11), -1, e);
    send_frame(8'h22, 1'b0, good_par(8'h22), -1, e);
    check("b2b_data", rx_data, 8'h22);
    check("b2b_overrun", overrun, 1);
    pulse_ack();
    tick(1);
    check("b2b_ack_overrun", overrun, 0);
    send_frame(8'h33, 1'b0, good_par(8'h33), -1, e);
    fork
      send_frame(8'h44, 1'b0, good_par(8'h44), -1, e);
      begin
        tick(LAT - 1);
        pulse_ack();
      end
    join
    check("ackcommit_data", rx_data, 8'h44);
    check("ackcommit_over", uart_over, 1);
    check("ackcommit_overrun", overrun, 0);

    // reset during data bit 4, then a clean frame
    send_frame(8'h96, 1'b0, good_par(8'h96), 4, e);
    tick(2 * BD);
    check("after_rst_over", uart_over, 0);
    send_frame(8'h5A, 1'b0, good_par(8'h5A), -1, e);
    tick(2);
    check("5a_data", rx_data, 8'h5A);
    check("5a_over", uart_over, 1);
    pulse_ack();
    tick(2);

    // randomised traffic with random acknowledges
    rnd_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch_pulse($urandom_range(1, MID - 2));
      end else begin
        d    = DB'($urandom);
        bad  = ($urandom_range(0, 5) == 0);
        pbit = good_par(d) ^ (PB == 1 && $urandom_range(0, 4) == 0);
        send_frame(d, bad, pbit, -1, e);
        gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
        if (bad && gap < 2) gap = 2;
        if (gap > 0) tick(gap);
      end
    end
    rnd_en = 1'b0;
    tick(LAT + 2 * BD);
    pulse_ack();
    tick(1);
    check("final_ack_clears", uart_over, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
